adc_serial_sample_reader: RTL

//  Consumer end of the divided serial clock produced by the 32fm timer: takes that s_clk
//  as a bit strobe, frames an ADC conversion (cs_n), and shifts in the serial data.
//  It delivers one parallel audio sample per frame with a 1-cycle valid pulse to the

---
 rtl/adc_serial_sample_reader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/adc_serial_sample_reader.sv
// adc_serial_sample_reader
//   Frames one ADC conversion per request and shifts in its serial data.
//   s_clk is the divided bit clock from the timer. It is sampled in the clk
//   domain and used only as a bit strobe, never as a clock. Each frame yields
//   one parallel sample and a 1-cycle sample_valid pulse.
//
// Parameters
//   FRAME_BITS   s_clk rising edges per frame (bits shifted in)
//   DATA_W       sample width; the last DATA_W bits of the frame, MSB-first
//   QUIET_EDGES  s_clk falling edges with cs_n high between frames (>=1)
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   s_clk         bit clock from the timer (clk domain)
//   sdata         ADC serial data (asynchronous to clk)
//   start         level request; a frame begins on an s_clk fall while idle
//   cs_n          ADC chip select, active-low
//   busy          high whenever the FSM is not idle
//   sample        last accepted sample
//   sample_valid  1-cycle pulse when sample updates
//   frame_err     (ADC_LEADING_ZERO_CHECK_EN only) 1-cycle pulse when a
//                 discarded leading bit was 1; the sample is rejected
//
// Build option
//   `define ADC_LEADING_ZERO_CHECK_EN adds frame_err and leading-bit checking.
module adc_serial_sample_reader #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_W      = 12,
  parameter int QUIET_EDGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_clk,
  input  logic              sdata,
  input  logic              start,
  output logic              cs_n,
  output logic              busy,
  output logic [DATA_W-1:0] sample,
`ifdef ADC_LEADING_ZERO_CHECK_EN
  output logic              frame_err,
`endif
  output logic              sample_valid
);

  localparam int BCNT_W = $clog2(FRAME_BITS + 1);
  localparam int QCNT_W = $clog2(QUIET_EDGES + 1);
  // History kept in the shift register: only bits that can still reach the
  // sample (or the leading-bit check) are stored; older bits fall off.
`ifdef ADC_LEADING_ZERO_CHECK_EN
  localparam int HIST_W = FRAME_BITS - 1;
`else
  localparam int HIST_W = DATA_W - 1;
`endif

  if (DATA_W > FRAME_BITS || DATA_W < 2) begin : g_bad_width
    $error("adc_serial_sample_reader: need 2 <= DATA_W <= FRAME_BITS");
  end
  if (QUIET_EDGES < 1) begin : g_bad_quiet
    $error("adc_serial_sample_reader: QUIET_EDGES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t              state_q, state_d;
  logic                s_clk_d;
  logic                rise, fall;
  logic                sdata_meta, sdata_s;
  logic [BCNT_W-1:0]   bitcnt;
  logic [QCNT_W-1:0]   quiet_cnt;
  logic [HIST_W-1:0]   shreg;
  logic [HIST_W:0]     frame_word;
  logic                last_rise;
  logic                lead_err;

  assign rise       = s_clk & ~s_clk_d;
  assign fall       = ~s_clk & s_clk_d;
  // Shift register contents including the bit arriving on this rise.
  assign frame_word = {shreg, sdata_s};
  assign last_rise  = (state_q == SHIFT) && rise &&
                      (bitcnt == BCNT_W'(FRAME_BITS - 1));

`ifdef ADC_LEADING_ZERO_CHECK_EN
  if (FRAME_BITS > DATA_W) begin : g_lead
    assign lead_err = |frame_word[FRAME_BITS-1:DATA_W];
  end else begin : g_nolead
    assign lead_err = 1'b0;
  end
`else
  assign lead_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and status
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (start && fall) state_d = SHIFT;
      SHIFT:   if (last_rise) state_d = DONE;
      DONE:    state_d = GAP;
      GAP:     if (fall && quiet_cnt == QCNT_W'(QUIET_EDGES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge detect, synchronizer, shift datapath and registered outputs.
  // The sample is captured on the final rise so that it is already stable
  // in the DONE cycle, where sample_valid is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_clk_d      <= 1'b0;
      sdata_meta   <= 1'b0;
      sdata_s      <= 1'b0;
      bitcnt       <= '0;
      quiet_cnt    <= '0;
      shreg        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      cs_n         <= 1'b1;
`ifdef ADC_LEADING_ZERO_CHECK_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      s_clk_d      <= s_clk;
      sdata_meta   <= sdata;
      sdata_s      <= sdata_meta;
      sample_valid <= 1'b0;
`ifdef ADC_LEADING_ZERO_CHECK_EN
      frame_err    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start && fall) begin
            cs_n   <= 1'b0;
            bitcnt <= '0;
          end
        end
        SHIFT: begin
          if (rise) begin
            shreg  <= frame_word[HIST_W-1:0];
            bitcnt <= bitcnt + 1'b1;
            if (last_rise) begin
              if (lead_err) begin
`ifdef ADC_LEADING_ZERO_CHECK_EN
                frame_err <= 1'b1;
`endif
              end else begin
                sample       <= frame_word[DATA_W-1:0];
                sample_valid <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          cs_n      <= 1'b1;
          quiet_cnt <= '0;
        end
        GAP: begin
          if (fall) quiet_cnt <= quiet_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
